// File: rtl/pixel_ctrl_pkg.sv
// pixel_ctrl_pkg: state encoding, default parameters and sizing helper for the row readout sequencer
package pixel_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_SETTLE, S_CONVERT, S_OUTPUT, S_RELEASE, S_DONE
  } state_t;
  localparam int DEF_WIDTH = 2;
  localparam int DEF_ROWS = 2;
  localparam int DEF_RESOLUTION = 8;
  localparam int DEF_ERASE_CYCLES = 4;
  localparam int DEF_EXPOSE_CYCLES = 16;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_ADC_TIMEOUT = 64;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/pixel_row_readout_ctrl_row_phase_timer.sv
// row_phase_timer: loadable down-counter that parks at zero and flags it
module row_phase_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/pixel_row_readout_ctrl.sv
// pixel_row_readout_ctrl: erase/expose a pixel row, then select, settle, convert and stream each pixel code
module pixel_row_readout_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROWS = DEF_ROWS,
  parameter int RESOLUTION = DEF_RESOLUTION,
  parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
  parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int ADC_TIMEOUT = DEF_ADC_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  row_erase,
  output logic                  row_expose,
  output logic [WIDTH-1:0]      row_select,
  output logic                  adc_enable,
  input  logic [RESOLUTION-1:0] adc_data,
  input  logic                  adc_done,
  output logic [RESOLUTION-1:0] pix_data,
  output logic [WIDTH-1:0]      pix_index,
  output logic                  pix_err,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int TW = $clog2(max4(ERASE_CYCLES, EXPOSE_CYCLES, SETTLE_CYCLES, ADC_TIMEOUT) + 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [RESOLUTION-1:0] data_q, data_d;
  logic err_q, err_d;
  logic erase_q, expose_q, enable_q, valid_q, busy_q, done_q;
  logic ld, zero;
  logic [TW-1:0] ld_val;
  row_phase_timer #(.W(TW)) u_timer (
    .clk(clk), .reset(reset), .load(ld), .load_val(ld_val), .zero(zero)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    data_d = data_q;
    err_d = err_q;
    ld = 1'b0;
    ld_val = '0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ERASE;
        idx_d = '0;
        ld = 1'b1;
        ld_val = TW'(ERASE_CYCLES - 1);
      end
      S_ERASE: if (zero) begin
        state_d = S_EXPOSE;
        ld = 1'b1;
        ld_val = TW'(EXPOSE_CYCLES - 1);
      end
      S_EXPOSE: if (zero) begin
        state_d = S_SETTLE;
        ld = 1'b1;
        ld_val = TW'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: if (zero) begin
        state_d = S_CONVERT;
        ld = 1'b1;
        ld_val = TW'(ADC_TIMEOUT - 1);
      end
      S_CONVERT: if (adc_done || zero) begin
        state_d = S_OUTPUT;
        data_d = adc_done ? adc_data : '1;
        err_d = !adc_done;
      end
      S_OUTPUT: if (pix_ready) state_d = S_RELEASE;
      S_RELEASE: if (!adc_done) begin
        if (idx_q == WIDTH'(ROWS - 1)) state_d = S_DONE;
        else begin
          state_d = S_SETTLE;
          idx_d = idx_q + 1'b1;
          ld = 1'b1;
          ld_val = TW'(SETTLE_CYCLES - 1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      erase_q <= 1'b0;
      expose_q <= 1'b0;
      enable_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      err_q <= err_d;
      erase_q <= state_d == S_ERASE;
      expose_q <= state_d == S_EXPOSE;
      enable_q <= state_d == S_CONVERT;
      valid_q <= state_d == S_OUTPUT;
      busy_q <= state_d != S_IDLE;
      done_q <= state_d == S_DONE;
    end
  assign row_erase = erase_q;
  assign row_expose = expose_q;
  assign row_select = idx_q;
  assign adc_enable = enable_q;
  assign pix_data = data_q;
  assign pix_index = idx_q;
  assign pix_err = err_q;
  assign pix_valid = valid_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule
